// File: rtl/rsa_mont_const_gen.sv
// Serial generator for the Montgomery constant 2^CONST_EXP mod M, one modular doubling per clock.
// Optional RSA_MONT_AUTOSTART_EN: relaunch automatically whenever mod_in differs from the captured M.
module rsa_mont_const_gen #(
  parameter int WIDTH     = 8,
  parameter int CONST_EXP = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] mod_in,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             err,
  output logic [WIDTH-1:0] const_out
);

  localparam int CW = (CONST_EXP > 1) ? $clog2(CONST_EXP) : 1;
  localparam logic [CW-1:0] LAST = CW'(CONST_EXP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r_dbl;
  logic             trig_idle;
  logic             trig_run;
  logic             load;
  logic             step;
  logic             last_step;
  logic             drop;

`ifdef RSA_MONT_AUTOSTART_EN
  logic mod_changed;
  assign mod_changed = (mod_in != m);
  assign trig_idle   = start | mod_changed | ~valid;
  assign trig_run    = mod_changed;
`else
  assign trig_idle = start;
  assign trig_run  = 1'b0;
`endif

  // r < m always holds, so 2r < 2m fits in WIDTH+1 bits and one subtract reduces it.
  always_comb begin
    t = {r, 1'b0};
    if (t >= {1'b0, m}) r_dbl = WIDTH'(t - {1'b0, m});
    else                r_dbl = t[WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (trig_idle && !abort) begin
          load       = 1'b1;
          state_next = (mod_in == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          drop       = 1'b1;
          state_next = IDLE;
        end else if (trig_run) begin
          load       = 1'b1;
          state_next = (mod_in == '0) ? FIN : RUN;
        end else begin
          step = 1'b1;
          if (cnt == LAST) begin
            last_step  = 1'b1;
            state_next = FIN;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
        drop       = abort;
      end
      default: state_next = IDLE;
    endcase
    busy = (state != IDLE);
    done = (state == FIN) && !abort;
  end

  // The result is written on the edge entering FIN so it is visible during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m         <= '0;
      r         <= '0;
      cnt       <= '0;
      const_out <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        m   <= mod_in;
        cnt <= '0;
        err <= (mod_in == '0) | ~mod_in[0];
        r   <= (mod_in == WIDTH'(1)) ? '0 : WIDTH'(1);
        if (mod_in == '0) begin
          const_out <= '0;
          valid     <= 1'b1;
        end else begin
          valid <= 1'b0;
        end
      end
      if (step) begin
        r   <= r_dbl;
        cnt <= cnt + CW'(1);
      end
      if (last_step) begin
        const_out <= r_dbl;
        valid     <= 1'b1;
      end
      if (drop) valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rsa_mont_const_gen.sv
// Directed bench for rsa_mont_const_gen (WIDTH=8, CONST_EXP=16) with hand-computed constants.
module tb_rsa_mont_const_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] mod_in = 8'h00;
  logic       busy;
  logic       done;
  logic       valid;
  logic       err;
  logic [7:0] const_out;

  int total = 0;
  int bad = 0;

  rsa_mont_const_gen #(.WIDTH(8), .CONST_EXP(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mod_in(mod_in),
    .busy(busy), .done(done), .valid(valid), .err(err), .const_out(const_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifndef RSA_MONT_AUTOSTART_EN
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; mod_in = 8'h00;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (const_out !== 8'h00) begin bad++; $display("FAIL reset_const got=%h exp=00", const_out); end
  endtask

  task automatic test_const(input logic [7:0] mod, input logic [7:0] exp_c,
                            input logic exp_e, input int exp_lat);
    int lat;
    mod_in = mod; start = 1'b1;
    tick();
    start = 1'b0;
    mod_in = mod ^ 8'h5A;
    lat = 1;
    while (!done && lat < 64) begin
      tick();
      lat++;
    end
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL latency m=%h got=%0d exp=%0d", mod, lat, exp_lat); end
    total++; if (const_out !== exp_c) begin bad++; $display("FAIL const m=%h got=%h exp=%h", mod, const_out, exp_c); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL valid m=%h got=%b exp=1", mod, valid); end
    total++; if (err !== exp_e) begin bad++; $display("FAIL err m=%h got=%b exp=%b", mod, err, exp_e); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_at_done m=%h got=%b exp=1", mod, busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_after m=%h got=%b exp=0", mod, busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width m=%h got=%b exp=0", mod, done); end
    total++; if (const_out !== exp_c) begin bad++; $display("FAIL const_hold m=%h got=%h exp=%h", mod, const_out, exp_c); end
  endtask

  task automatic test_abort(input logic [7:0] prev_c);
    int seen;
    mod_in = 8'hFB; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", valid); end
    total++; if (const_out !== prev_c) begin bad++; $display("FAIL abort_const got=%h exp=%h", const_out, prev_c); end
    seen = 0;
    repeat (25) begin
      if (done) seen++;
      if (busy) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", seen); end
  endtask

  task automatic test_abort_fin();
    mod_in = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    abort = 1'b1;
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_fin_done got=%b exp=0", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_fin_busy got=%b exp=1", busy); end
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_fin_idle got=%b exp=0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_fin_valid got=%b exp=0", valid); end
  endtask

  task automatic test_start_abort_idle();
    int seen;
    mod_in = 8'h03; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_wins got=%b exp=0", busy); end
    seen = 0;
    repeat (20) begin
      if (done) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_wins_done got=%0d exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    mod_in = 8'h10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL mid_err_set got=%b exp=1", err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b exp=0", err); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", valid); end
    total++; if (const_out !== 8'h00) begin bad++; $display("FAIL mid_rst_const got=%h exp=00", const_out); end
  endtask
`else
  task automatic test_autostart();
    int lat;
    int seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mod_in = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    lat = 0;
    while (!done && lat < 64) begin
      tick();
      lat++;
    end
    total++; if (lat !== 17) begin bad++; $display("FAIL auto_latency got=%0d exp=17", lat); end
    total++; if (const_out !== 8'h01) begin bad++; $display("FAIL auto_const got=%h exp=01", const_out); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL auto_valid got=%b exp=1", valid); end
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL auto_settled got=%b exp=0", busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    mod_in = 8'hFB;
    lat = 0;
    while (!done && lat < 64) begin
      tick();
      lat++;
    end
    total++; if (lat !== 17) begin bad++; $display("FAIL auto_restart_latency got=%0d exp=17", lat); end
    total++; if (const_out !== 8'h19) begin bad++; $display("FAIL auto_restart_const got=%h exp=19", const_out); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL auto_restart_err got=%b exp=0", err); end
    tick();
    seen = 0;
    repeat (20) begin
      if (done) seen++;
      if (busy) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL auto_single_done got=%0d exp=0", seen); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL auto_final_valid got=%b exp=1", valid); end
  endtask
`endif

  initial begin
`ifndef RSA_MONT_AUTOSTART_EN
    test_reset();
    test_const(8'hFB, 8'h19, 1'b0, 17);
    test_const(8'hFF, 8'h01, 1'b0, 17);
    test_const(8'h03, 8'h01, 1'b0, 17);
    test_const(8'h01, 8'h00, 1'b0, 17);
    test_const(8'h00, 8'h00, 1'b1, 1);
    test_const(8'h10, 8'h00, 1'b1, 17);
    test_const(8'hFB, 8'h19, 1'b0, 17);
    test_abort(8'h19);
    test_const(8'hFB, 8'h19, 1'b0, 17);
    test_abort_fin();
    test_start_abort_idle();
    test_reset_mid();
    test_const(8'h0B, 8'h09, 1'b0, 17);
`else
    test_autostart();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
